ibex_rf_wr_arbiter: RTL and testbench

Arbitrates the single register-file write port between three producers: LSU load return, the writeback stage (ID/EX results), and an external multi-cycle unit such as a coprocessor. The arbiter sits between those producers and the register file. LSU writes can never stall, so the writeback path carries a one-entry holding buffer. A starvation counter guarantees that the external requester makes forward progress.

---
 rtl/ibex_rf_wr_arbiter_pkg.sv | 29 ++
 rtl/ibex_rf_wr_skid.sv | 65 ++++++
 rtl/ibex_rf_wr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ibex_rf_wr_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_wr_arbiter_pkg
// Description : Shared types and widths for the register-file write arbiter.
//               rf_wr_src_e tags which producer owns the single RF write
//               port in a given cycle (used for tracing).
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_rf_wr_arbiter_pkg;

    localparam int unsigned RfAddrW    = 5;
    localparam int unsigned RfDataW    = 32;
    localparam int unsigned StarveCntW = 4;

    typedef enum logic [1:0] {
        RF_WR_NONE = 2'd0,
        RF_WR_LSU  = 2'd1,
        RF_WR_WB   = 2'd2,
        RF_WR_EXT  = 2'd3
    } rf_wr_src_e;

    // Writes to x0 are architecturally discarded; they must never occupy the
    // port or the holding buffer.
    function automatic logic rf_addr_is_x0(input logic [RfAddrW-1:0] addr);
        return (addr == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_rf_wr_skid.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_wr_skid
// Description : One-entry holding buffer for a non-stallable write path.
//               A capture loads the entry; a drain empties it. The caller
//               guarantees capture only happens while the entry is empty.
//               Outputs read as zero while empty so stale contents never
//               reach hazard or forwarding logic.
// Ports       : clk_i/rst_ni   - clock, asynchronous active-low reset
//               capture_i      - load waddr_i/wdata_i into the entry
//               drain_i        - entry consumed this cycle
//               waddr_i/wdata_i- write to capture
//               valid_o        - entry occupied
//               waddr_o/wdata_o- buffered write (zero when empty)
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rf_wr_skid
    import ibex_rf_wr_arbiter_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               capture_i,
    input  logic               drain_i,
    input  logic [RfAddrW-1:0] waddr_i,
    input  logic [RfDataW-1:0] wdata_i,
    output logic               valid_o,
    output logic [RfAddrW-1:0] waddr_o,
    output logic [RfDataW-1:0] wdata_o
);

    logic               valid_q, valid_d;
    logic [RfAddrW-1:0] waddr_q, waddr_d;
    logic [RfDataW-1:0] wdata_q, wdata_d;

    always_comb begin
        valid_d = valid_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (capture_i) begin
            valid_d = 1'b1;
            waddr_d = waddr_i;
            wdata_d = wdata_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign valid_o = valid_q;
    assign waddr_o = valid_q ? waddr_q : '0;
    assign wdata_o = valid_q ? wdata_q : '0;

endmodule
`default_nettype wire

// File: rtl/ibex_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_wr_arbiter
// Description : Arbitrates the single register-file write port between the
//               LSU (never stalls), the writeback stage (one-entry holding
//               buffer absorbs LSU collisions) and an external multi-cycle
//               unit (guaranteed progress via a starvation counter).
// Ports       : clk_i/rst_ni          - clock, asynchronous active-low reset
//               lsu_we/waddr/wdata_i  - LSU load return, always granted
//               wb_valid/waddr/wdata_i, wb_ready_o   - writeback request
//               ext_valid/waddr/wdata_i, ext_ready_o - external request
//               rf_we/waddr/wdata_o   - register-file write port
//               rf_wr_src_o           - owner of this cycle's write
//               pend_valid/waddr/wdata_o - holding buffer view for ID
// Parameters  : StarveLimit (1..15) - denied EXT cycles before EXT outranks WB
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rf_wr_arbiter
    import ibex_rf_wr_arbiter_pkg::*;
#(
    parameter int unsigned StarveLimit = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               lsu_we_i,
    input  logic [RfAddrW-1:0] lsu_waddr_i,
    input  logic [RfDataW-1:0] lsu_wdata_i,

    input  logic               wb_valid_i,
    input  logic [RfAddrW-1:0] wb_waddr_i,
    input  logic [RfDataW-1:0] wb_wdata_i,
    output logic               wb_ready_o,

    input  logic               ext_valid_i,
    input  logic [RfAddrW-1:0] ext_waddr_i,
    input  logic [RfDataW-1:0] ext_wdata_i,
    output logic               ext_ready_o,

    output logic               rf_we_o,
    output logic [RfAddrW-1:0] rf_waddr_o,
    output logic [RfDataW-1:0] rf_wdata_o,
    output rf_wr_src_e         rf_wr_src_o,

    output logic               pend_valid_o,
    output logic [RfAddrW-1:0] pend_waddr_o,
    output logic [RfDataW-1:0] pend_wdata_o
);

    localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(StarveLimit);

    logic                  buf_valid;
    logic [RfAddrW-1:0]    buf_waddr;
    logic [RfDataW-1:0]    buf_wdata;
    logic                  buf_capture;

    logic [StarveCntW-1:0] starve_cnt_q, starve_cnt_d;
    logic                  ext_starved;

    logic                  wb_accept;
    logic                  wb_real;
    logic                  ext_real;

    logic                  grant_lsu, grant_ext, grant_buf, grant_wb;
    logic                  ext_ready;

    assign ext_starved = (starve_cnt_q == StarveMax);
    assign wb_ready_o  = ~buf_valid;
    assign wb_accept   = wb_valid_i & wb_ready_o;
    // Only non-x0 requests occupy the port; x0 requests are accepted and dropped.
    assign wb_real     = wb_accept & ~rf_addr_is_x0(wb_waddr_i);
    assign ext_real    = ~rf_addr_is_x0(ext_waddr_i);

    // Priority walk. An accepted x0 EXT request takes its rank's acceptance
    // but leaves the port free for the next-ranked requester.
    always_comb begin
        logic port_busy;
        port_busy = 1'b0;
        grant_lsu = 1'b0;
        grant_ext = 1'b0;
        grant_buf = 1'b0;
        grant_wb  = 1'b0;
        ext_ready = 1'b0;

        if (lsu_we_i) begin
            grant_lsu = 1'b1;
            port_busy = 1'b1;
        end
        if (!port_busy && ext_valid_i && ext_starved) begin
            ext_ready = 1'b1;
            if (ext_real) begin
                grant_ext = 1'b1;
                port_busy = 1'b1;
            end
        end
        if (!port_busy && buf_valid) begin
            grant_buf = 1'b1;
            port_busy = 1'b1;
        end
        if (!port_busy && wb_real) begin
            grant_wb  = 1'b1;
            port_busy = 1'b1;
        end
        if (!port_busy && ext_valid_i && !ext_ready) begin
            ext_ready = 1'b1;
            if (ext_real) begin
                grant_ext = 1'b1;
            end
        end
    end

    assign ext_ready_o = ext_ready;
    // buf_valid gates wb_accept, so capture can never overlap a drain.
    assign buf_capture = wb_real & ~grant_wb;

    always_comb begin
        rf_we_o     = 1'b0;
        rf_waddr_o  = '0;
        rf_wdata_o  = '0;
        rf_wr_src_o = RF_WR_NONE;
        if (grant_lsu) begin
            rf_we_o     = 1'b1;
            rf_waddr_o  = lsu_waddr_i;
            rf_wdata_o  = lsu_wdata_i;
            rf_wr_src_o = RF_WR_LSU;
        end else if (grant_ext) begin
            rf_we_o     = 1'b1;
            rf_waddr_o  = ext_waddr_i;
            rf_wdata_o  = ext_wdata_i;
            rf_wr_src_o = RF_WR_EXT;
        end else if (grant_buf) begin
            rf_we_o     = 1'b1;
            rf_waddr_o  = buf_waddr;
            rf_wdata_o  = buf_wdata;
            rf_wr_src_o = RF_WR_WB;
        end else if (grant_wb) begin
            rf_we_o     = 1'b1;
            rf_waddr_o  = wb_waddr_i;
            rf_wdata_o  = wb_wdata_i;
            rf_wr_src_o = RF_WR_WB;
        end
    end

    ibex_rf_wr_skid u_skid (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .capture_i (buf_capture),
        .drain_i   (grant_buf),
        .waddr_i   (wb_waddr_i),
        .wdata_i   (wb_wdata_i),
        .valid_o   (buf_valid),
        .waddr_o   (buf_waddr),
        .wdata_o   (buf_wdata)
    );

    assign pend_valid_o = buf_valid;
    assign pend_waddr_o = buf_waddr;
    assign pend_wdata_o = buf_wdata;

    // Counts consecutive denied EXT cycles; saturates so a starved EXT that is
    // still losing to the LSU keeps its top rank until it is served.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ext_ready || !ext_valid_i) begin
            starve_cnt_d = '0;
        end else if (!ext_starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifndef SYNTHESIS
    // At most one producer drives the port in any cycle.
    a_single_writer : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({grant_lsu, grant_ext, grant_buf, grant_wb}));

    // EXT must hold its request, with stable payload, until accepted.
    a_ext_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ext_valid_i && !ext_ready_o) |=>
            (ext_valid_i && $stable(ext_waddr_i) && $stable(ext_wdata_i)));

    a_no_x0_write : assert property (@(posedge clk_i) disable iff (!rst_ni)
        rf_we_o |-> (rf_waddr_o != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_rf_wr_arbiter
// Description : Directed self-checking bench for ibex_rf_wr_arbiter.
//               Inputs change on the falling edge; outputs are checked 1ns
//               later, well away from the rising (active) edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_rf_wr_arbiter;
    import ibex_rf_wr_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_we_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        wb_valid_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        wb_ready_o;
    logic        ext_valid_i;
    logic [4:0]  ext_waddr_i;
    logic [31:0] ext_wdata_i;
    logic        ext_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    rf_wr_src_e  rf_wr_src_o;
    logic        pend_valid_o;
    logic [4:0]  pend_waddr_o;
    logic [31:0] pend_wdata_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    ibex_rf_wr_arbiter #(.StarveLimit(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lsu_we_i     (lsu_we_i),
        .lsu_waddr_i  (lsu_waddr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .wb_valid_i   (wb_valid_i),
        .wb_waddr_i   (wb_waddr_i),
        .wb_wdata_i   (wb_wdata_i),
        .wb_ready_o   (wb_ready_o),
        .ext_valid_i  (ext_valid_i),
        .ext_waddr_i  (ext_waddr_i),
        .ext_wdata_i  (ext_wdata_i),
        .ext_ready_o  (ext_ready_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .rf_wr_src_o  (rf_wr_src_o),
        .pend_valid_o (pend_valid_o),
        .pend_waddr_o (pend_waddr_o),
        .pend_wdata_o (pend_wdata_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        lsu_we_i    = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
        wb_valid_i  = 1'b0; wb_waddr_i  = '0; wb_wdata_i  = '0;
        ext_valid_i = 1'b0; ext_waddr_i = '0; ext_wdata_i = '0;
    endtask

    task automatic chk_write(input string tag, input logic [4:0] a, input logic [31:0] d,
                             input rf_wr_src_e s);
        chk({tag, ".we"},    32'(rf_we_o),    32'd1);
        chk({tag, ".waddr"}, 32'(rf_waddr_o), 32'(a));
        chk({tag, ".wdata"}, rf_wdata_o,      d);
        chk({tag, ".src"},   32'(rf_wr_src_o), 32'(s));
    endtask

    task automatic chk_nowrite(input string tag);
        chk({tag, ".we"},    32'(rf_we_o),     32'd0);
        chk({tag, ".waddr"}, 32'(rf_waddr_o),  32'd0);
        chk({tag, ".src"},   32'(rf_wr_src_o), 32'(RF_WR_NONE));
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("rst.wb_ready",   32'(wb_ready_o),   32'd1);
        chk("rst.ext_ready",  32'(ext_ready_o),  32'd0);
        chk("rst.rf_we",      32'(rf_we_o),      32'd0);
        chk("rst.rf_waddr",   32'(rf_waddr_o),   32'd0);
        chk("rst.rf_wdata",   rf_wdata_o,        32'd0);
        chk("rst.src",        32'(rf_wr_src_o),  32'(RF_WR_NONE));
        chk("rst.pend_valid", 32'(pend_valid_o), 32'd0);
        chk("rst.pend_waddr", 32'(pend_waddr_o), 32'd0);
        chk("rst.pend_wdata", pend_wdata_o,      32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // ---------------- WB bypass ----------------
        @(negedge clk_i);
        wb_valid_i = 1'b1; wb_waddr_i = 5'd5; wb_wdata_i = 32'hA5A5_0001;
        #1;
        chk_write("byp", 5'd5, 32'hA5A5_0001, RF_WR_WB);
        chk("byp.wb_ready",   32'(wb_ready_o),   32'd1);
        chk("byp.pend_valid", 32'(pend_valid_o), 32'd0);
        @(negedge clk_i);
        idle();
        #1;
        chk("byp1.pend_valid", 32'(pend_valid_o), 32'd0);
        chk_nowrite("byp1");

        // ---------------- LSU collision ----------------
        @(negedge clk_i);
        lsu_we_i   = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h1111_1111;
        wb_valid_i = 1'b1; wb_waddr_i  = 5'd8; wb_wdata_i  = 32'h2222_2222;
        #1;
        chk_write("col0", 5'd7, 32'h1111_1111, RF_WR_LSU);
        chk("col0.wb_ready", 32'(wb_ready_o), 32'd1);
        @(negedge clk_i);
        idle();
        #1;
        chk_write("col1", 5'd8, 32'h2222_2222, RF_WR_WB);
        chk("col1.wb_ready",   32'(wb_ready_o),   32'd0);
        chk("col1.pend_valid", 32'(pend_valid_o), 32'd1);
        chk("col1.pend_waddr", 32'(pend_waddr_o), 32'd8);
        chk("col1.pend_wdata", pend_wdata_o,      32'h2222_2222);
        @(negedge clk_i);
        #1;
        chk("col2.wb_ready",   32'(wb_ready_o),   32'd1);
        chk("col2.pend_valid", 32'(pend_valid_o), 32'd0);
        chk("col2.pend_waddr", 32'(pend_waddr_o), 32'd0);
        chk_nowrite("col2");

        // ---------------- starvation ----------------
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            ext_valid_i = 1'b1; ext_waddr_i = 5'd9; ext_wdata_i = 32'hE000_0009;
            wb_valid_i  = 1'b1; wb_waddr_i  = 5'(10 + i); wb_wdata_i = 32'(i);
            #1;
            chk($sformatf("stv%0d.ext_ready", i), 32'(ext_ready_o), 32'd0);
            chk_write($sformatf("stv%0d", i), 5'(10 + i), 32'(i), RF_WR_WB);
        end
        @(negedge clk_i);
        wb_waddr_i = 5'd14; wb_wdata_i = 32'hB0B0_0014;
        #1;
        chk("stv4.ext_ready", 32'(ext_ready_o), 32'd1);
        chk("stv4.wb_ready",  32'(wb_ready_o),  32'd1);
        chk_write("stv4", 5'd9, 32'hE000_0009, RF_WR_EXT);
        @(negedge clk_i);
        idle();
        #1;
        chk("stv5.pend_valid", 32'(pend_valid_o), 32'd1);
        chk_write("stv5", 5'd14, 32'hB0B0_0014, RF_WR_WB);
        @(negedge clk_i);
        #1;
        chk_nowrite("stv6");

        // ------------- LSU over starved EXT (counter restarts at 0) -------------
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            ext_valid_i = 1'b1; ext_waddr_i = 5'd9; ext_wdata_i = 32'hE000_0019;
            wb_valid_i  = 1'b1; wb_waddr_i  = 5'(16 + i); wb_wdata_i = 32'(16 + i);
            #1;
            chk($sformatf("lse%0d.ext_ready", i), 32'(ext_ready_o), 32'd0);
            chk_write($sformatf("lse%0d", i), 5'(16 + i), 32'(16 + i), RF_WR_WB);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            wb_valid_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
            lsu_we_i = 1'b1; lsu_waddr_i = 5'(20 + i); lsu_wdata_i = 32'h4C4C_4C4C;
            #1;
            chk($sformatf("lse%0d.ext_ready", 4 + i), 32'(ext_ready_o), 32'd0);
            chk_write($sformatf("lse%0d", 4 + i), 5'(20 + i), 32'h4C4C_4C4C, RF_WR_LSU);
        end
        @(negedge clk_i);
        lsu_we_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
        #1;
        chk("lse6.ext_ready", 32'(ext_ready_o), 32'd1);
        chk_write("lse6", 5'd9, 32'hE000_0019, RF_WR_EXT);
        @(negedge clk_i);
        idle();
        #1;
        chk_nowrite("lse7");

        // ---------------- x0 filtering ----------------
        @(negedge clk_i);
        wb_valid_i  = 1'b1; wb_waddr_i  = 5'd0; wb_wdata_i  = 32'hDEAD_BEEF;
        ext_valid_i = 1'b1; ext_waddr_i = 5'd3; ext_wdata_i = 32'h3333_3333;
        #1;
        chk("x0.wb_ready",  32'(wb_ready_o),  32'd1);
        chk("x0.ext_ready", 32'(ext_ready_o), 32'd1);
        chk_write("x0", 5'd3, 32'h3333_3333, RF_WR_EXT);
        @(negedge clk_i);
        idle();
        #1;
        chk("x0n.pend_valid", 32'(pend_valid_o), 32'd0);
        chk("x0n.wb_ready",   32'(wb_ready_o),   32'd1);
        chk_nowrite("x0n");

        // ---------------- reset mid-operation ----------------
        @(negedge clk_i);
        lsu_we_i   = 1'b1; lsu_waddr_i = 5'd1; lsu_wdata_i = 32'h0000_0001;
        wb_valid_i = 1'b1; wb_waddr_i  = 5'd2; wb_wdata_i  = 32'h1234_5678;
        @(negedge clk_i);
        wb_valid_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
        #1;
        chk("mrst.pend_valid_pre", 32'(pend_valid_o), 32'd1);
        chk("mrst.pend_waddr_pre", 32'(pend_waddr_o), 32'd2);
        idle();
        rst_ni = 1'b0;
        #1;
        chk("mrst.pend_valid", 32'(pend_valid_o), 32'd0);
        chk("mrst.pend_wdata", pend_wdata_o,      32'd0);
        chk_nowrite("mrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk_nowrite("mrst1");
        chk("mrst1.wb_ready", 32'(wb_ready_o), 32'd1);
        @(negedge clk_i);
        #1;
        chk_nowrite("mrst2");
        chk("mrst2.pend_valid", 32'(pend_valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
